// File: rtl/multi_pwm_breather.sv
// Multi-channel PWM with a shared breathing (sawtooth/triangle) duty generator.
// Duty changes are staged in a shadow register and only reach the comparator at a period wrap.
module multi_pwm_breather #(
    parameter int RESOLUTION = 8,
    parameter int CHANNELS   = 3,
    parameter int DVSR       = 4882,
    parameter int GRAD_MAX   = 2_499_999
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [1:0]          mode,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_start
);

    localparam int PW     = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int GW     = (GRAD_MAX > 0) ? $clog2(GRAD_MAX + 1) : 1;
    localparam int OFFSET = (2 ** RESOLUTION) / CHANNELS;

    localparam logic [PW-1:0]         PRESC_LAST = PW'(DVSR - 1);
    localparam logic [GW-1:0]         GRAD_LAST  = GW'(GRAD_MAX);
    localparam logic [RESOLUTION-1:0] CNT_LAST   = '1;
    localparam logic [RESOLUTION:0]   DUTY_FULL  = {1'b1, {RESOLUTION{1'b0}}};

    logic [PW-1:0]         presc_q, presc_d;
    logic [RESOLUTION-1:0] cnt_q, cnt_d;
    logic [GW-1:0]         grad_q, grad_d;
    logic [CHANNELS-1:0]   pwm_q, pwm_d;
    logic                  period_start_q, period_start_d;
    logic [RESOLUTION:0]   shadow_q [CHANNELS];
    logic [RESOLUTION:0]   shadow_d [CHANNELS];
    logic [RESOLUTION:0]   active_q [CHANNELS];
    logic [RESOLUTION:0]   active_d [CHANNELS];
    logic [CHANNELS-1:0]   up_q, up_d;

    logic tick;
    logic wrap;
    logic step;

    always_comb begin
        tick = en && (presc_q == PRESC_LAST);
        wrap = tick && (cnt_q == CNT_LAST);
        step = en && (grad_q == GRAD_LAST);

        presc_d = presc_q;
        cnt_d   = cnt_q;
        grad_d  = grad_q;
        if (en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            grad_d  = step ? '0 : grad_q + 1'b1;
            if (tick) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Registered outputs hold their value while disabled so a pause resumes seamlessly.
    always_comb begin
        pwm_d          = pwm_q;
        period_start_d = period_start_q;
        if (en) begin
            period_start_d = wrap;
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_d[i] = ({1'b0, cnt_q} < active_q[i]);
            end
        end
    end

    // Active duty latches the pre-step shadow on wrap, so a coincident step lands one period later.
    always_comb begin
        up_d = up_q;
        for (int i = 0; i < CHANNELS; i++) begin
            shadow_d[i] = shadow_q[i];
            active_d[i] = wrap ? shadow_q[i] : active_q[i];
            if (step) begin
                case (mode)
                    2'd0: begin
                        shadow_d[i] = (shadow_q[i] == DUTY_FULL) ? '0 : shadow_q[i] + 1'b1;
                    end
                    2'd1: begin
                        if (up_q[i]) begin
                            if (shadow_q[i] == DUTY_FULL) begin
                                up_d[i]     = 1'b0;
                                shadow_d[i] = shadow_q[i] - 1'b1;
                            end else begin
                                shadow_d[i] = shadow_q[i] + 1'b1;
                            end
                        end else begin
                            if (shadow_q[i] == '0) begin
                                up_d[i]     = 1'b1;
                                shadow_d[i] = shadow_q[i] + 1'b1;
                            end else begin
                                shadow_d[i] = shadow_q[i] - 1'b1;
                            end
                        end
                    end
                    default: begin
                        shadow_d[i] = shadow_q[i];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            cnt_q          <= '0;
            grad_q         <= '0;
            pwm_q          <= '0;
            period_start_q <= 1'b0;
            up_q           <= '1;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= (RESOLUTION + 1)'(i * OFFSET);
                active_q[i] <= '0;
            end
        end else begin
            presc_q        <= presc_d;
            cnt_q          <= cnt_d;
            grad_q         <= grad_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            up_q           <= up_d;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
        end
    end

    assign pwm          = en ? pwm_q : '0;
    assign period_start = en & period_start_q;

endmodule

// File: tb/tb_multi_pwm_breather.sv
// Randomized bench for multi_pwm_breather against a model driven by an enabled-cycle count.
// Counters are derived arithmetically from that count; duties follow the mode rules directly.
module tb_multi_pwm_breather;

    localparam int R      = 3;
    localparam int C      = 3;
    localparam int D      = 2;
    localparam int G      = 3;
    localparam int FULL   = 2 ** R;
    localparam int PERIOD = D * FULL;
    localparam int GSTEP  = G + 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [1:0]   mode;
    logic [C-1:0] pwm;
    logic         period_start;

    int           m_n;
    int           m_shadow [C];
    int           m_active [C];
    bit           m_up [C];
    logic [C-1:0] m_pwm_q;
    logic         m_ps_q;

    int n_checks;
    int n_fail;

    multi_pwm_breather #(
        .RESOLUTION (R),
        .CHANNELS   (C),
        .DVSR       (D),
        .GRAD_MAX   (G)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .mode         (mode),
        .pwm          (pwm),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_n = 0;
        for (int i = 0; i < C; i++) begin
            m_shadow[i] = i * (FULL / C);
            m_active[i] = 0;
            m_up[i]     = 1'b1;
        end
        m_pwm_q = '0;
        m_ps_q  = 1'b0;
    endtask

    task automatic modelEdge(input logic e, input logic [1:0] md);
        bit wrap;
        bit step;
        int phase;
        if (!e) return;
        wrap  = (m_n % PERIOD) == PERIOD - 1;
        step  = (m_n % GSTEP) == GSTEP - 1;
        phase = (m_n / D) % FULL;
        for (int i = 0; i < C; i++) begin
            m_pwm_q[i] = (phase < m_active[i]);
        end
        m_ps_q = wrap;
        for (int i = 0; i < C; i++) begin
            if (wrap) m_active[i] = m_shadow[i];
            if (step) begin
                if (md == 2'd0) begin
                    m_shadow[i] = (m_shadow[i] == FULL) ? 0 : m_shadow[i] + 1;
                end else if (md == 2'd1) begin
                    if (m_up[i] && m_shadow[i] == FULL) m_up[i] = 1'b0;
                    else if (!m_up[i] && m_shadow[i] == 0) m_up[i] = 1'b1;
                    m_shadow[i] = m_up[i] ? m_shadow[i] + 1 : m_shadow[i] - 1;
                end
            end
        end
        m_n++;
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] md);
        en   = e;
        mode = md;
        @(posedge clk);
        modelEdge(e, md);
        @(negedge clk);
        checkOutput("pwm", pwm, e ? m_pwm_q : '0);
        checkOutput("period_start", period_start, e ? m_ps_q : 1'b0);
    endtask

    initial begin
        int         first;
        int         second;
        int         gap;
        bit         found;
        logic [1:0] cur_mode;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        mode     = 2'd0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_pwm", pwm, 0);
        checkOutput("reset_period_start", period_start, 0);
        rst_n = 1'b1;

        first  = 0;
        second = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b1, 2'd1);
            if (period_start === 1'b1) begin
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
        end
        checkOutput("first_period_start", first, 16);
        checkOutput("period_length", second - first, 16);

        repeat (160) applyStimulus(1'b1, 2'd1);
        repeat (200) applyStimulus(1'b1, 2'd0);

        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b1, 2'd0);
            if (period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("align_period_start", found, 1);
        repeat (5) applyStimulus(1'b1, 2'd0);
        repeat (10) applyStimulus(1'b0, 2'd0);
        gap = 0;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b1, 2'd0);
            if (period_start === 1'b1) begin
                gap = k;
                break;
            end
        end
        checkOutput("paused_period_gap", 15 + gap, 26);

        cur_mode = 2'd1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 19) == 0) cur_mode = 2'($urandom_range(0, 3));
            applyStimulus($urandom_range(0, 7) != 0, cur_mode);
        end

        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b1, 2'd1);
            if (pwm !== '0) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("pwm_high_before_reset", found, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_reset_pwm", pwm, 0);
        checkOutput("async_reset_period_start", period_start, 0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("reset_hold_pwm", pwm, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) applyStimulus(1'b1, 2'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
